mem_port_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/rr_arb2.sv | 21 ++
 rtl/mem_port_arbiter.sv | 110 +++++++++++
 tb/tb_mem_port_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the two-port memory arbiter: FSM states,
// port identifiers and the byte-range check.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  // 64-bit arithmetic holds any ADDR_WIDTH+1 sum, so address wrap shows up as an error
  function automatic logic range_err(input logic [63:0] addr,
                                     input logic [63:0] nbytes,
                                     input logic [63:0] limit);
    return (addr + nbytes - 64'd1) > (limit - 64'd1);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick; grant is one-hot, bit index = port id.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       if_req,
  input  logic       d_req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (if_req && d_req)
      gnt = (last == PORT_IF) ? 2'b10 : 2'b01;
    else if (d_req)
      gnt = 2'b10;
    else if (if_req)
      gnt = 2'b01;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single Memory port between instruction fetch and load/store,
// running each access as an IDLE -> ACCESS -> RESP transaction.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BYTE_SIZE  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_BYTES  = 301
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   if_req,
  input  logic [ADDR_WIDTH-1:0]  if_addr,
  output logic                   if_ack,
  output logic [BYTE_SIZE*8-1:0] if_rdata,
  input  logic                   d_req,
  input  logic                   d_we,
  input  logic [ADDR_WIDTH-1:0]  d_addr,
  input  logic [BYTE_SIZE*8-1:0] d_wdata,
  output logic                   d_ack,
  output logic [BYTE_SIZE*8-1:0] d_rdata,
  output logic                   d_err,
  output logic                   if_err,
  output logic                   mem_WE,
  output logic [ADDR_WIDTH-1:0]  mem_ADDR,
  output logic [BYTE_SIZE*8-1:0] mem_WD,
  input  logic [BYTE_SIZE*8-1:0] mem_RD
);

  state_t                state;
  logic                  last;
  logic                  win_d;
  logic                  acc_we;
  logic                  acc_err;
  logic [1:0]            gnt;
  logic                  pick_d;
  logic [ADDR_WIDTH-1:0] pick_addr;
  logic                  pick_err;

  rr_arb2 u_arb (
    .if_req (if_req),
    .d_req  (d_req),
    .last   (last),
    .gnt    (gnt)
  );

  assign pick_d    = gnt[PORT_D];
  assign pick_addr = pick_d ? d_addr : if_addr;
  assign pick_err  = range_err(64'(pick_addr), 64'(BYTE_SIZE), 64'(MEM_BYTES));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= PORT_IF;
      win_d    <= 1'b0;
      acc_we   <= 1'b0;
      acc_err  <= 1'b0;
      mem_WE   <= 1'b0;
      mem_ADDR <= '0;
      mem_WD   <= '0;
      if_ack   <= 1'b0;
      d_ack    <= 1'b0;
      if_err   <= 1'b0;
      d_err    <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|gnt) begin
            state    <= ACCESS;
            last     <= pick_d;
            win_d    <= pick_d;
            mem_ADDR <= pick_addr;
            acc_err  <= pick_err;
            acc_we   <= pick_d && d_we;
            if (pick_d)
              mem_WD <= d_wdata;
            mem_WE   <= pick_d && d_we && !pick_err;
          end
        end
        ACCESS: begin
          // Memory commits/reads at this edge; suppressed accesses leave rdata untouched
          mem_WE <= 1'b0;
          state  <= RESP;
          if (win_d) begin
            d_ack <= 1'b1;
            d_err <= acc_err;
            if (!acc_we && !acc_err)
              d_rdata <= mem_RD;
          end else begin
            if_ack <= 1'b1;
            if_err <= acc_err;
            if (!acc_err)
              if_rdata <= mem_RD;
          end
        end
        RESP: begin
          if_ack <= 1'b0;
          d_ack  <= 1'b0;
          if_err <= 1'b0;
          d_err  <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural byte-addressed memory.
module tb_mem_port_arbiter;
  localparam int BYTE_SIZE  = 4;
  localparam int ADDR_WIDTH = 32;
  localparam int MEM_BYTES  = 301;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_ack, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_ack, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_WE;
  logic [31:0] mem_ADDR, mem_WD, mem_RD;

  logic [7:0] mem [0:MEM_BYTES-1];
  int vectors = 0;
  int miscompares = 0;
  int we_cycles = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.BYTE_SIZE(BYTE_SIZE), .ADDR_WIDTH(ADDR_WIDTH), .MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err), .if_err(if_err),
    .mem_WE(mem_WE), .mem_ADDR(mem_ADDR), .mem_WD(mem_WD), .mem_RD(mem_RD)
  );

  // Little-endian combinational read; bytes past the array read as zero
  always_comb begin
    longint idx;
    mem_RD = '0;
    for (int i = 0; i < BYTE_SIZE; i++) begin
      idx = longint'(mem_ADDR) + i;
      if (idx < MEM_BYTES) mem_RD[i*8 +: 8] = mem[int'(idx)];
    end
  end

  always @(posedge clk) begin
    longint idx;
    if (mem_WE)
      for (int i = 0; i < BYTE_SIZE; i++) begin
        idx = longint'(mem_ADDR) + i;
        if (idx < MEM_BYTES) mem[int'(idx)] = mem_WD[i*8 +: 8];
      end
  end

  always @(negedge clk) if (mem_WE) we_cycles++;

  function automatic logic [31:0] mem_word(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  task automatic do_data(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic err);
    @(negedge clk);
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    lat = -1; err = 1'bx;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (d_ack) begin lat = i; err = d_err; break; end
    end
    d_req = 1'b0; d_we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_fetch(input logic [31:0] addr, output int lat, output logic err);
    @(negedge clk);
    if_req = 1'b1; if_addr = addr;
    lat = -1; err = 1'bx;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (if_ack) begin lat = i; err = if_err; break; end
    end
    if_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({if_ack, d_ack, if_err, d_err, mem_WE} !== 5'b0) begin
      miscompares++; $display("[TB] FAIL reset_flags: got %b expected 00000", {if_ack, d_ack, if_err, d_err, mem_WE});
    end
    vectors++;
    if ({mem_ADDR, mem_WD, if_rdata, d_rdata} !== 128'b0) begin
      miscompares++; $display("[TB] FAIL reset_regs: got %h expected 0", {mem_ADDR, mem_WD, if_rdata, d_rdata});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_load();
    int lat; logic err; int we0;
    mem[32] = 8'h01; mem[33] = 8'h02; mem[34] = 8'h03; mem[35] = 8'h04;
    we0 = we_cycles;
    do_data(1'b0, 32'd32, 32'h0, lat, err);
    vectors++;
    if (lat !== 2) begin miscompares++; $display("[TB] FAIL load_latency: got %0d expected 2", lat); end
    vectors++;
    if (d_rdata !== 32'h04030201) begin miscompares++; $display("[TB] FAIL load_rdata: got %h expected 04030201", d_rdata); end
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL load_err: got %b expected 0", err); end
    vectors++;
    if (we_cycles - we0 !== 0) begin miscompares++; $display("[TB] FAIL load_no_we: got %0d expected 0", we_cycles - we0); end
  endtask

  task automatic test_store_fetch();
    int lat; logic err; int we0;
    we0 = we_cycles;
    do_data(1'b1, 32'd40, 32'hDEADBEEF, lat, err);
    vectors++;
    if (lat !== 2 || err !== 1'b0) begin miscompares++; $display("[TB] FAIL store_ack: got lat %0d err %b expected 2 0", lat, err); end
    vectors++;
    if (we_cycles - we0 !== 1) begin miscompares++; $display("[TB] FAIL store_we_cycles: got %0d expected 1", we_cycles - we0); end
    vectors++;
    if (mem_word(40) !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL store_mem: got %h expected deadbeef", mem_word(40)); end
    vectors++;
    if (d_rdata !== 32'h04030201) begin miscompares++; $display("[TB] FAIL store_keeps_rdata: got %h expected 04030201", d_rdata); end
    do_fetch(32'd40, lat, err);
    vectors++;
    if (lat !== 2 || err !== 1'b0) begin miscompares++; $display("[TB] FAIL fetch_ack: got lat %0d err %b expected 2 0", lat, err); end
    vectors++;
    if (if_rdata !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL fetch_rdata: got %h expected deadbeef", if_rdata); end
  endtask

  task automatic test_contention();
    logic order [0:7];
    int ack_at [0:7];
    int n = 0;
    int both = 0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'd32;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd40;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (if_ack && d_ack) both++;
      if ((if_ack || d_ack) && n < 8) begin
        order[n] = d_ack; ack_at[n] = i; n++;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    vectors++;
    if (n !== 4) begin miscompares++; $display("[TB] FAIL contention_acks: got %0d expected 4", n); end
    vectors++;
    if (both !== 0) begin miscompares++; $display("[TB] FAIL contention_dual_ack: got %0d expected 0", both); end
    if (n >= 4) begin
      vectors++;
      if ({order[0], order[1], order[2], order[3]} !== 4'b1010) begin
        miscompares++; $display("[TB] FAIL contention_order: got %b expected 1010 (D,IF,D,IF)", {order[0], order[1], order[2], order[3]});
      end
      vectors++;
      if (ack_at[0] !== 2 || ack_at[3] !== 11) begin
        miscompares++; $display("[TB] FAIL contention_timing: got first %0d last %0d expected 2 11", ack_at[0], ack_at[3]);
      end
    end
    vectors++;
    if (d_rdata !== 32'hDEADBEEF || if_rdata !== 32'h04030201) begin
      miscompares++; $display("[TB] FAIL contention_rdata: got d %h if %h expected deadbeef 04030201", d_rdata, if_rdata);
    end
  endtask

  task automatic test_range_error();
    int lat; logic err; int we0;
    for (int k = 0; k < 5; k++) mem[296+k] = 8'hA0 + 8'(k);
    we0 = we_cycles;
    do_data(1'b1, 32'd298, 32'h11223344, lat, err);
    vectors++;
    if (lat !== 2 || err !== 1'b1) begin miscompares++; $display("[TB] FAIL oob_store_ack: got lat %0d err %b expected 2 1", lat, err); end
    vectors++;
    if (we_cycles - we0 !== 0) begin miscompares++; $display("[TB] FAIL oob_store_we: got %0d expected 0", we_cycles - we0); end
    vectors++;
    if (mem_word(297) !== 32'hA4A3A2A1) begin miscompares++; $display("[TB] FAIL oob_store_mem: got %h expected a4a3a2a1", mem_word(297)); end
    do_data(1'b0, 32'd297, 32'h0, lat, err);
    vectors++;
    if (err !== 1'b0 || d_rdata !== 32'hA4A3A2A1) begin
      miscompares++; $display("[TB] FAIL edge_load: got err %b data %h expected 0 a4a3a2a1", err, d_rdata);
    end
    do_data(1'b0, 32'd298, 32'h0, lat, err);
    vectors++;
    if (err !== 1'b1 || d_rdata !== 32'hA4A3A2A1) begin
      miscompares++; $display("[TB] FAIL oob_load: got err %b data %h expected 1 a4a3a2a1", err, d_rdata);
    end
    do_fetch(32'hFFFFFFFE, lat, err);
    vectors++;
    if (lat !== 2 || err !== 1'b1 || if_rdata !== 32'h04030201) begin
      miscompares++; $display("[TB] FAIL wrap_fetch: got lat %0d err %b data %h expected 2 1 04030201", lat, err, if_rdata);
    end
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    logic first_d = 1'bx;
    // Reset while a load is in RESP
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd32;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (d_ack) begin seen = 1'b1; break; end
    end
    vectors++;
    if (!seen) begin miscompares++; $display("[TB] FAIL mid_load_ack: got no ack expected ack within 8 cycles"); end
    rst_n = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (d_ack !== 1'b0 || d_rdata !== 32'h0) begin
      miscompares++; $display("[TB] FAIL reset_in_resp: got ack %b data %h expected 0 0", d_ack, d_rdata);
    end
    rst_n = 1'b1;
    for (int k = 60; k < 64; k++) mem[k] = 8'h00;
    // Reset at the closing edge of a store's ACCESS cycle
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'd60; d_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    vectors++;
    if (mem_WE !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_store_we: got %b expected 1", mem_WE); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (mem_word(60) !== 32'hCAFEF00D) begin miscompares++; $display("[TB] FAIL reset_store_commit: got %h expected cafef00d", mem_word(60)); end
    vectors++;
    if (d_ack !== 1'b0 || mem_WE !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_store_ack: got ack %b we %b expected 0 0", d_ack, mem_WE);
    end
    d_req = 1'b0; d_we = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    // After reset the data port wins the first contention
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'd32;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd60;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (if_ack || d_ack) begin first_d = d_ack; break; end
    end
    if_req = 1'b0; d_req = 1'b0;
    vectors++;
    if (first_d !== 1'b1 || d_rdata !== 32'hCAFEF00D) begin
      miscompares++; $display("[TB] FAIL post_reset_priority: got d_first %b data %h expected 1 cafef00d", first_d, d_rdata);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    for (int k = 0; k < MEM_BYTES; k++) mem[k] = 8'h00;
    test_reset();
    test_single_load();
    test_store_fetch();
    test_contention();
    test_range_error();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
